// File: rtl/sdram_pkg.sv
// Shared constants, bank indices and channel state type for the SDRAM
// request generator and its triple-buffer allocator.
package sdram_pkg;

   localparam int unsigned BURST_LEN    = 512;
   localparam int unsigned FIFO_DEPTH   = 1024;
   localparam int unsigned LVL_W        = 11;
   localparam int unsigned ROW_W        = 13;
   localparam int unsigned FRAME_BURSTS = 600;
   localparam int unsigned HOLD_CYC     = 4;
   localparam int unsigned BANK_W       = 2;

   localparam logic [BANK_W-1:0] BANK0 = 2'd0;
   localparam logic [BANK_W-1:0] BANK1 = 2'd1;
   localparam logic [BANK_W-1:0] BANK2 = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } chan_state_e;

   // Lowest of the three frame banks that is neither a nor b.
   function automatic logic [BANK_W-1:0] free_bank(input logic [BANK_W-1:0] a,
                                                   input logic [BANK_W-1:0] b);
      logic [BANK_W-1:0] sel;
      sel = BANK2;
      if (a != BANK1 && b != BANK1) sel = BANK1;
      if (a != BANK0 && b != BANK0) sel = BANK0;
      return sel;
   endfunction

endpackage

// File: rtl/frame_buf_sel.sv
// Triple-buffer bank allocator: computes post-edge writer/reader banks and the
// last completed frame so the writer never lands on the bank being displayed.
module frame_buf_sel
   import sdram_pkg::*;
(
   input  logic              wr_wrap,
   input  logic              rd_wrap,
   input  logic              frame_valid,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic [BANK_W-1:0] rd_bank,
   input  logic [BANK_W-1:0] last_done,
   output logic [BANK_W-1:0] wr_bank_nxt_c,
   output logic [BANK_W-1:0] rd_bank_nxt_c,
   output logic [BANK_W-1:0] last_done_nxt_c,
   output logic              rd_load_c
);

   // The first completed frame forces a reader wrap onto it; a reader wrap
   // landing with a writer wrap takes the bank that just completed.
   always_comb begin
      last_done_nxt_c = last_done;
      rd_bank_nxt_c   = rd_bank;
      wr_bank_nxt_c   = wr_bank;
      rd_load_c       = rd_wrap || (wr_wrap && !frame_valid);

      if (wr_wrap) last_done_nxt_c = wr_bank;
      if (rd_load_c) rd_bank_nxt_c = last_done_nxt_c;
      if (wr_wrap) wr_bank_nxt_c = free_bank(wr_bank, rd_bank_nxt_c);
   end

endmodule

// File: rtl/sdram_req_gen.sv
// Burst request generator: raises full-row write/read requests from FIFO fill
// levels and walks bank/row addresses through a three-bank frame buffer.
module sdram_req_gen #(
   parameter int unsigned BURST_LEN    = sdram_pkg::BURST_LEN,
   parameter int unsigned FIFO_DEPTH   = sdram_pkg::FIFO_DEPTH,
   parameter int unsigned LVL_W        = sdram_pkg::LVL_W,
   parameter int unsigned ROW_W        = sdram_pkg::ROW_W,
   parameter int unsigned FRAME_BURSTS = sdram_pkg::FRAME_BURSTS,
   parameter int unsigned HOLD_CYC     = sdram_pkg::HOLD_CYC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init_done,
   input  logic             cam_frame_start,
   input  logic [LVL_W-1:0] wfifo_level,
   input  logic [LVL_W-1:0] rfifo_level,
   input  logic             wr_sdram_ack,
   input  logic             rd_sdram_ack,
   output logic             wr_sdram_req,
   output logic             rd_sdram_req,
   output logic [1:0]       wr_bank,
   output logic [ROW_W-1:0] wr_row,
   output logic [1:0]       rd_bank,
   output logic [ROW_W-1:0] rd_row,
   output logic             frame_valid
);
   import sdram_pkg::*;

   localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

   chan_state_e       wr_state;
   chan_state_e       rd_state;
   logic [HOLD_W-1:0] wr_hold_cnt;
   logic [HOLD_W-1:0] rd_hold_cnt;
   logic [1:0]        last_done;
   logic              frame_start_pend;

   logic              wr_ack_c;
   logic              rd_ack_c;
   logic              wr_wrap_c;
   logic              rd_wrap_c;
   logic              wr_start_c;
   logic              rd_start_c;
   logic              rd_load_c;
   logic [1:0]        wr_bank_nxt_c;
   logic [1:0]        rd_bank_nxt_c;
   logic [1:0]        last_done_nxt_c;

   // Acks only count while their own channel is waiting in REQ.
   always_comb begin
      wr_ack_c   = (wr_state == REQ) && wr_sdram_ack;
      rd_ack_c   = (rd_state == REQ) && rd_sdram_ack;
      wr_wrap_c  = wr_ack_c && (wr_row == ROW_W'(FRAME_BURSTS - 1));
      rd_wrap_c  = rd_ack_c && (rd_row == ROW_W'(FRAME_BURSTS - 1));
      wr_start_c = init_done && (wfifo_level >= LVL_W'(BURST_LEN));
      rd_start_c = init_done && frame_valid &&
                   (rfifo_level <= LVL_W'(FIFO_DEPTH - BURST_LEN));
   end

   frame_buf_sel u_frame_buf_sel (
      .wr_wrap         (wr_wrap_c),
      .rd_wrap         (rd_wrap_c),
      .frame_valid     (frame_valid),
      .wr_bank         (wr_bank),
      .rd_bank         (rd_bank),
      .last_done       (last_done),
      .wr_bank_nxt_c   (wr_bank_nxt_c),
      .rd_bank_nxt_c   (rd_bank_nxt_c),
      .last_done_nxt_c (last_done_nxt_c),
      .rd_load_c       (rd_load_c)
   );

   // Write channel FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state     <= IDLE;
         wr_sdram_req <= 1'b0;
         wr_hold_cnt  <= '0;
      end else begin
         case (wr_state)
            IDLE: begin
               wr_hold_cnt <= '0;
               if (wr_start_c) begin
                  wr_state     <= REQ;
                  wr_sdram_req <= 1'b1;
               end
            end
            REQ: begin
               if (wr_ack_c) begin
                  wr_state     <= HOLD;
                  wr_sdram_req <= 1'b0;
                  wr_hold_cnt  <= '0;
               end
            end
            HOLD: begin
               if (wr_hold_cnt == HOLD_W'(HOLD_CYC - 1)) wr_state <= IDLE;
               else wr_hold_cnt <= wr_hold_cnt + HOLD_W'(1);
            end
            default: begin
               wr_state     <= IDLE;
               wr_sdram_req <= 1'b0;
            end
         endcase
      end
   end

   // Read channel FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state     <= IDLE;
         rd_sdram_req <= 1'b0;
         rd_hold_cnt  <= '0;
      end else begin
         case (rd_state)
            IDLE: begin
               rd_hold_cnt <= '0;
               if (rd_start_c) begin
                  rd_state     <= REQ;
                  rd_sdram_req <= 1'b1;
               end
            end
            REQ: begin
               if (rd_ack_c) begin
                  rd_state     <= HOLD;
                  rd_sdram_req <= 1'b0;
                  rd_hold_cnt  <= '0;
               end
            end
            HOLD: begin
               if (rd_hold_cnt == HOLD_W'(HOLD_CYC - 1)) rd_state <= IDLE;
               else rd_hold_cnt <= rd_hold_cnt + HOLD_W'(1);
            end
            default: begin
               rd_state     <= IDLE;
               rd_sdram_req <= 1'b0;
            end
         endcase
      end
   end

   // Address walk; a VSYNC during an open write burst is applied at its ack.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bank          <= BANK0;
         wr_row           <= '0;
         rd_bank          <= BANK0;
         rd_row           <= '0;
         last_done        <= BANK0;
         frame_valid      <= 1'b0;
         frame_start_pend <= 1'b0;
      end else begin
         if (wr_ack_c) begin
            if (wr_wrap_c || frame_start_pend || cam_frame_start) wr_row <= '0;
            else wr_row <= wr_row + ROW_W'(1);
            frame_start_pend <= 1'b0;
         end else if (cam_frame_start) begin
            if (wr_state == REQ) frame_start_pend <= 1'b1;
            else wr_row <= '0;
         end

         if (rd_load_c) rd_row <= '0;
         else if (rd_ack_c) rd_row <= rd_row + ROW_W'(1);

         if (wr_wrap_c) frame_valid <= 1'b1;

         wr_bank   <= wr_bank_nxt_c;
         rd_bank   <= rd_bank_nxt_c;
         last_done <= last_done_nxt_c;
      end
   end

endmodule

// File: tb/tb_sdram_req_gen.sv
// Directed bench for sdram_req_gen with a three-burst frame: request timing,
// triple-buffer rotation, VSYNC handling, init gating and mid-burst reset.
module tb_sdram_req_gen;

   localparam int unsigned LVL_W = 11;
   localparam int unsigned ROW_W = 13;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             init_done = 1'b0;
   logic             cam_frame_start = 1'b0;
   logic [LVL_W-1:0] wfifo_level = '0;
   logic [LVL_W-1:0] rfifo_level = '0;
   logic             wr_sdram_ack = 1'b0;
   logic             rd_sdram_ack = 1'b0;
   logic             wr_sdram_req;
   logic             rd_sdram_req;
   logic [1:0]       wr_bank;
   logic [ROW_W-1:0] wr_row;
   logic [1:0]       rd_bank;
   logic [ROW_W-1:0] rd_row;
   logic             frame_valid;

   int errors = 0;
   int checks = 0;

   sdram_req_gen #(.FRAME_BURSTS(3)) dut (
      .clk             (clk),
      .rst             (rst),
      .init_done       (init_done),
      .cam_frame_start (cam_frame_start),
      .wfifo_level     (wfifo_level),
      .rfifo_level     (rfifo_level),
      .wr_sdram_ack    (wr_sdram_ack),
      .rd_sdram_ack    (rd_sdram_ack),
      .wr_sdram_req    (wr_sdram_req),
      .rd_sdram_req    (rd_sdram_req),
      .wr_bank         (wr_bank),
      .wr_row          (wr_row),
      .rd_bank         (rd_bank),
      .rd_row          (rd_row),
      .frame_valid     (frame_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_burst();
      wfifo_level = 11'd512;
      tick();
      wfifo_level = '0;
      wr_sdram_ack = 1'b1;
      tick();
      wr_sdram_ack = 1'b0;
      repeat (4) tick();
   endtask

   task automatic rd_burst();
      rfifo_level = 11'd512;
      tick();
      rfifo_level = 11'd1000;
      rd_sdram_ack = 1'b1;
      tick();
      rd_sdram_ack = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      repeat (2) tick();
      rst = 1'b0;
      checks++; if (wr_sdram_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req: got %b want 0", wr_sdram_req); end
      checks++; if (rd_sdram_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", rd_sdram_req); end
      checks++; if (wr_bank !== 2'd0) begin errors++; $display("FAIL reset_wr_bank: got %0d want 0", wr_bank); end
      checks++; if (wr_row !== 13'd0) begin errors++; $display("FAIL reset_wr_row: got %0d want 0", wr_row); end
      checks++; if (rd_bank !== 2'd0) begin errors++; $display("FAIL reset_rd_bank: got %0d want 0", rd_bank); end
      checks++; if (rd_row !== 13'd0) begin errors++; $display("FAIL reset_rd_row: got %0d want 0", rd_row); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
      init_done = 1'b1;
   endtask

   task automatic test_write_req();
      logic held;
      logic quiet;
      rfifo_level = '0;
      wfifo_level = 11'd511;
      repeat (2) tick();
      checks++; if (wr_sdram_req !== 1'b0) begin errors++; $display("FAIL wr_req_below_burst: got %b want 0", wr_sdram_req); end
      wfifo_level = 11'd512;
      tick();
      checks++; if (wr_sdram_req !== 1'b1) begin errors++; $display("FAIL wr_req_rise: got %b want 1", wr_sdram_req); end
      wfifo_level = '0;
      held = 1'b1;
      quiet = 1'b1;
      repeat (20) begin
         tick();
         if (wr_sdram_req !== 1'b1) held = 1'b0;
         if (rd_sdram_req !== 1'b0) quiet = 1'b0;
      end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL wr_req_held: got %b want 1", held); end
      checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rd_req_no_frame: got %b want 1", quiet); end
      checks++; if (wr_row !== 13'd0) begin errors++; $display("FAIL wr_row_before_ack: got %0d want 0", wr_row); end
      wr_sdram_ack = 1'b1;
      tick();
      wr_sdram_ack = 1'b0;
      checks++; if (wr_sdram_req !== 1'b0) begin errors++; $display("FAIL wr_req_drop: got %b want 0", wr_sdram_req); end
      checks++; if (wr_row !== 13'd1) begin errors++; $display("FAIL wr_row_inc: got %0d want 1", wr_row); end
      // spurious acks during write HOLD and read IDLE
      wfifo_level = 11'd512;
      wr_sdram_ack = 1'b1;
      rd_sdram_ack = 1'b1;
      tick();
      wr_sdram_ack = 1'b0;
      rd_sdram_ack = 1'b0;
      quiet = (wr_sdram_req === 1'b0);
      checks++; if (wr_row !== 13'd1) begin errors++; $display("FAIL wr_row_spurious: got %0d want 1", wr_row); end
      checks++; if (rd_row !== 13'd0) begin errors++; $display("FAIL rd_row_spurious: got %0d want 0", rd_row); end
      repeat (3) begin
         tick();
         if (wr_sdram_req !== 1'b0) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL wr_hold_gap: got %b want 1", quiet); end
      tick();
      checks++; if (wr_sdram_req !== 1'b1) begin errors++; $display("FAIL wr_req_after_hold: got %b want 1", wr_sdram_req); end
      wfifo_level = '0;
      wr_sdram_ack = 1'b1;
      tick();
      wr_sdram_ack = 1'b0;
      repeat (4) tick();
      checks++; if (wr_row !== 13'd2) begin errors++; $display("FAIL wr_row_second: got %0d want 2", wr_row); end
   endtask

   task automatic test_first_frame();
      rfifo_level = 11'd1000;
      wr_burst();
      checks++; if (wr_row !== 13'd0) begin errors++; $display("FAIL ff_wr_row: got %0d want 0", wr_row); end
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ff_frame_valid: got %b want 1", frame_valid); end
      checks++; if (rd_bank !== 2'd0) begin errors++; $display("FAIL ff_rd_bank: got %0d want 0", rd_bank); end
      checks++; if (wr_bank !== 2'd1) begin errors++; $display("FAIL ff_wr_bank: got %0d want 1", wr_bank); end
      checks++; if (rd_sdram_req !== 1'b0) begin errors++; $display("FAIL ff_rd_req_full: got %b want 0", rd_sdram_req); end
      rfifo_level = 11'd513;
      repeat (2) tick();
      checks++; if (rd_sdram_req !== 1'b0) begin errors++; $display("FAIL rd_req_above_room: got %b want 0", rd_sdram_req); end
      rfifo_level = 11'd512;
      tick();
      checks++; if (rd_sdram_req !== 1'b1) begin errors++; $display("FAIL rd_req_rise: got %b want 1", rd_sdram_req); end
      rfifo_level = 11'd1000;
      rd_sdram_ack = 1'b1;
      tick();
      rd_sdram_ack = 1'b0;
      checks++; if (rd_sdram_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop: got %b want 0", rd_sdram_req); end
      checks++; if (rd_row !== 13'd1) begin errors++; $display("FAIL rd_row_inc: got %0d want 1", rd_row); end
      repeat (4) tick();
   endtask

   task automatic test_rotation();
      repeat (3) wr_burst();
      checks++; if (wr_bank !== 2'd2) begin errors++; $display("FAIL rot_wr_bank: got %0d want 2", wr_bank); end
      checks++; if (rd_bank !== 2'd0) begin errors++; $display("FAIL rot_rd_bank_kept: got %0d want 0", rd_bank); end
      checks++; if (rd_row !== 13'd1) begin errors++; $display("FAIL rot_rd_row_kept: got %0d want 1", rd_row); end
      repeat (2) rd_burst();
      checks++; if (rd_bank !== 2'd1) begin errors++; $display("FAIL rot_rd_bank: got %0d want 1", rd_bank); end
      checks++; if (rd_row !== 13'd0) begin errors++; $display("FAIL rot_rd_row: got %0d want 0", rd_row); end
      checks++; if (wr_bank !== 2'd2) begin errors++; $display("FAIL rot_wr_bank_kept: got %0d want 2", wr_bank); end
   endtask

   task automatic test_same_cycle_wrap();
      repeat (2) wr_burst();
      repeat (2) rd_burst();
      checks++; if (wr_row !== 13'd2 || rd_row !== 13'd2) begin errors++; $display("FAIL sc_pre_rows: got %0d/%0d want 2/2", wr_row, rd_row); end
      wfifo_level = 11'd512;
      rfifo_level = 11'd512;
      tick();
      checks++; if (wr_sdram_req !== 1'b1 || rd_sdram_req !== 1'b1) begin errors++; $display("FAIL sc_both_req: got %b%b want 11", wr_sdram_req, rd_sdram_req); end
      wfifo_level = '0;
      rfifo_level = 11'd1000;
      wr_sdram_ack = 1'b1;
      rd_sdram_ack = 1'b1;
      tick();
      wr_sdram_ack = 1'b0;
      rd_sdram_ack = 1'b0;
      checks++; if (rd_bank !== 2'd2) begin errors++; $display("FAIL sc_rd_bank: got %0d want 2", rd_bank); end
      checks++; if (wr_bank !== 2'd0) begin errors++; $display("FAIL sc_wr_bank: got %0d want 0", wr_bank); end
      checks++; if (wr_row !== 13'd0 || rd_row !== 13'd0) begin errors++; $display("FAIL sc_rows: got %0d/%0d want 0/0", wr_row, rd_row); end
      repeat (4) tick();
   endtask

   task automatic test_frame_start();
      wr_burst();
      wfifo_level = 11'd512;
      tick();
      wfifo_level = '0;
      cam_frame_start = 1'b1;
      tick();
      cam_frame_start = 1'b0;
      checks++; if (wr_row !== 13'd1 || wr_sdram_req !== 1'b1) begin errors++; $display("FAIL fs_deferred: got row %0d req %b want row 1 req 1", wr_row, wr_sdram_req); end
      wr_sdram_ack = 1'b1;
      tick();
      wr_sdram_ack = 1'b0;
      checks++; if (wr_row !== 13'd0) begin errors++; $display("FAIL fs_ack_row: got %0d want 0", wr_row); end
      checks++; if (wr_bank !== 2'd0) begin errors++; $display("FAIL fs_bank_kept: got %0d want 0", wr_bank); end
      repeat (4) tick();
      repeat (3) rd_burst();
      checks++; if (rd_bank !== 2'd2 || rd_row !== 13'd0) begin errors++; $display("FAIL fs_last_done: got bank %0d row %0d want bank 2 row 0", rd_bank, rd_row); end
      repeat (2) wr_burst();
      checks++; if (wr_row !== 13'd2) begin errors++; $display("FAIL fs_pre_idle_row: got %0d want 2", wr_row); end
      cam_frame_start = 1'b1;
      tick();
      cam_frame_start = 1'b0;
      checks++; if (wr_row !== 13'd0 || wr_bank !== 2'd0) begin errors++; $display("FAIL fs_idle: got row %0d bank %0d want row 0 bank 0", wr_row, wr_bank); end
   endtask

   task automatic test_init_done();
      init_done = 1'b0;
      wfifo_level = 11'd512;
      repeat (3) tick();
      checks++; if (wr_sdram_req !== 1'b0) begin errors++; $display("FAIL init_block: got %b want 0", wr_sdram_req); end
      init_done = 1'b1;
      tick();
      init_done = 1'b0;
      wfifo_level = '0;
      repeat (3) tick();
      checks++; if (wr_sdram_req !== 1'b1) begin errors++; $display("FAIL init_pending_held: got %b want 1", wr_sdram_req); end
      wr_sdram_ack = 1'b1;
      tick();
      wr_sdram_ack = 1'b0;
      checks++; if (wr_sdram_req !== 1'b0 || wr_row !== 13'd1) begin errors++; $display("FAIL init_ack: got req %b row %0d want req 0 row 1", wr_sdram_req, wr_row); end
      repeat (4) tick();
      init_done = 1'b1;
   endtask

   task automatic test_reset_mid();
      logic quiet;
      wfifo_level = 11'd512;
      rfifo_level = 11'd512;
      tick();
      checks++; if (wr_sdram_req !== 1'b1 || rd_sdram_req !== 1'b1) begin errors++; $display("FAIL rm_both_req: got %b%b want 11", wr_sdram_req, rd_sdram_req); end
      rst = 1'b1;
      wfifo_level = '0;
      tick();
      rst = 1'b0;
      checks++; if ({wr_sdram_req, rd_sdram_req, frame_valid} !== 3'b000) begin errors++; $display("FAIL rm_flags: got %b want 000", {wr_sdram_req, rd_sdram_req, frame_valid}); end
      checks++; if ({wr_bank, rd_bank} !== 4'd0 || wr_row !== 13'd0 || rd_row !== 13'd0) begin errors++; $display("FAIL rm_addr: got %0d/%0d/%0d/%0d want 0/0/0/0", wr_bank, wr_row, rd_bank, rd_row); end
      quiet = 1'b1;
      repeat (3) begin
         tick();
         if (rd_sdram_req !== 1'b0) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rm_rd_blocked: got %b want 1", quiet); end
      repeat (2) wr_burst();
      checks++; if (rd_sdram_req !== 1'b0 || frame_valid !== 1'b0) begin errors++; $display("FAIL rm_partial: got req %b fv %b want 0 0", rd_sdram_req, frame_valid); end
      wr_burst();
      checks++; if (frame_valid !== 1'b1 || rd_sdram_req !== 1'b1) begin errors++; $display("FAIL rm_refill: got fv %b req %b want 1 1", frame_valid, rd_sdram_req); end
      checks++; if (rd_bank !== 2'd0 || wr_bank !== 2'd1) begin errors++; $display("FAIL rm_banks: got rd %0d wr %0d want rd 0 wr 1", rd_bank, wr_bank); end
   endtask

   initial begin
      test_reset();
      test_write_req();
      test_first_frame();
      test_rotation();
      test_same_cycle_wrap();
      test_frame_start();
      test_init_done();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
